// File: rtl/gc_cordic_pkg.sv
// rtl/gc_cordic_pkg.sv - shared CORDIC mode constants, tag record and width helper
package gc_cordic_pkg;

  localparam logic       c_MODE_VECTOR        = 1'b0;
  localparam logic       c_MODE_ROTATE        = 1'b1;
  localparam logic [1:0] c_SUBMODE_CIRCULAR   = 2'b00;
  localparam logic [1:0] c_SUBMODE_LINEAR     = 2'b01;
  localparam logic [1:0] c_SUBMODE_HYPERBOLIC = 2'b11;

  // Wide enough for the largest supported requester count (8).
  localparam int c_IDX_W = 3;

  typedef struct packed {
    logic               valid;
    logic [c_IDX_W-1:0] idx;
  } t_cordic_tag;

  function automatic int f_log2_ceil(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/gc_rr_select.sv
// rtl/gc_rr_select.sv - combinational round-robin picker starting the search at ptr_i
module gc_rr_select #(
  parameter int g_NUM_REQ = 4,
  parameter int g_IDX_W   = 2
) (
  input  logic [g_NUM_REQ-1:0] req_i,
  input  logic [g_IDX_W-1:0]   ptr_i,
  output logic [g_NUM_REQ-1:0] grant_o,
  output logic [g_IDX_W-1:0]   idx_o,
  output logic                 any_o
);

  logic [g_IDX_W:0] pos;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = '0;
    for (int i = 0; i < g_NUM_REQ; i++) begin
      // ptr_i + i folded back into 0..g_NUM_REQ-1 without a modulo operator
      pos = {1'b0, ptr_i} + (g_IDX_W+1)'(i);
      if (pos >= (g_IDX_W+1)'(g_NUM_REQ)) pos = pos - (g_IDX_W+1)'(g_NUM_REQ);
      if (!any_o && req_i[pos[g_IDX_W-1:0]]) begin
        any_o                     = 1'b1;
        grant_o[pos[g_IDX_W-1:0]] = 1'b1;
        idx_o                     = pos[g_IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/gc_cordic_arbiter.sv
// rtl/gc_cordic_arbiter.sv - shares one pipelined CORDIC among requesters, draining on mode switches
module gc_cordic_arbiter
  import gc_cordic_pkg::*;
#(
  parameter int g_NUM_REQ = 4,
  parameter int g_N       = 16,
  parameter int g_LATENCY = 17
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [g_NUM_REQ-1:0]     req_valid_i,
  output logic [g_NUM_REQ-1:0]     req_ready_o,
  input  logic [g_NUM_REQ-1:0]     req_mode_i,
  input  logic [2*g_NUM_REQ-1:0]   req_submode_i,
  input  logic [g_N*g_NUM_REQ-1:0] req_x_i,
  input  logic [g_N*g_NUM_REQ-1:0] req_y_i,
  input  logic [g_N*g_NUM_REQ-1:0] req_z_i,
  output logic [g_NUM_REQ-1:0]     rsp_valid_o,
  output logic [g_N-1:0]           rsp_x_o,
  output logic [g_N-1:0]           rsp_y_o,
  output logic [g_N-1:0]           rsp_z_o,
  output logic                     cor_mode_o,
  output logic [1:0]               cor_submode_o,
  output logic [g_N-1:0]           cor_x0_o,
  output logic [g_N-1:0]           cor_y0_o,
  output logic [g_N-1:0]           cor_z0_o,
  input  logic [g_N-1:0]           cor_xn_i,
  input  logic [g_N-1:0]           cor_yn_i,
  input  logic [g_N-1:0]           cor_zn_i,
  output logic                     busy_o
);

  localparam int c_IW = (f_log2_ceil(g_NUM_REQ) > 1) ? f_log2_ceil(g_NUM_REQ) : 1;
  // One tag stage sits beside cor_*0_o ahead of the latency pipe, so up to g_LATENCY+1 in flight.
  localparam int c_CW = f_log2_ceil(g_LATENCY + 2);

  typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} t_state;

  t_state               state, state_nxt;
  logic [c_IW-1:0]      rr_ptr, pend_idx, win_idx;
  logic [g_NUM_REQ-1:0] win_onehot, ret_onehot;
  logic                 win_any, win_mode, pend_mode, pend_valid;
  logic [1:0]           win_sub, pend_sub;
  logic [g_N-1:0]       win_x, win_y, win_z;
  logic                 grant, pend_load, mode_load, retire;
  logic [c_CW-1:0]      inflight;
  t_cordic_tag          tag_x0;
  t_cordic_tag          tag_pipe [g_LATENCY];

  gc_rr_select #(
    .g_NUM_REQ (g_NUM_REQ),
    .g_IDX_W   (c_IW)
  ) u_rr_select (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr),
    .grant_o (win_onehot),
    .idx_o   (win_idx),
    .any_o   (win_any)
  );

  always_comb begin
    win_mode   = 1'b0;
    win_sub    = 2'b00;
    win_x      = '0;
    win_y      = '0;
    win_z      = '0;
    pend_mode  = 1'b0;
    pend_sub   = 2'b00;
    pend_valid = 1'b0;
    ret_onehot = '0;
    for (int i = 0; i < g_NUM_REQ; i++) begin
      if (win_idx == c_IW'(i)) begin
        win_mode = req_mode_i[i];
        win_sub  = req_submode_i[2*i +: 2];
        win_x    = req_x_i[i*g_N +: g_N];
        win_y    = req_y_i[i*g_N +: g_N];
        win_z    = req_z_i[i*g_N +: g_N];
      end
      if (pend_idx == c_IW'(i)) begin
        pend_mode  = req_mode_i[i];
        pend_sub   = req_submode_i[2*i +: 2];
        pend_valid = req_valid_i[i];
      end
      ret_onehot[i] = tag_pipe[g_LATENCY-1].valid &&
                      (tag_pipe[g_LATENCY-1].idx == c_IDX_W'(i));
    end
  end

  assign retire = tag_pipe[g_LATENCY-1].valid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    pend_load = 1'b0;
    mode_load = 1'b0;
    case (state)
      ST_RUN: begin
        if (win_any) begin
          if ({win_mode, win_sub} == {cor_mode_o, cor_submode_o}) begin
            grant = 1'b1;
          end else begin
            pend_load = 1'b1;
            state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // A withdrawn request abandons the switch; otherwise wait for an empty pipe.
        if (!pend_valid) begin
          state_nxt = ST_RUN;
        end else if (inflight == '0) begin
          mode_load = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  assign req_ready_o = (grant && !rst_i) ? win_onehot : '0;
  assign busy_o      = (inflight != '0) || (state == ST_DRAIN);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr        <= '0;
      pend_idx      <= '0;
      cor_mode_o    <= c_MODE_ROTATE;
      cor_submode_o <= c_SUBMODE_CIRCULAR;
      cor_x0_o      <= '0;
      cor_y0_o      <= '0;
      cor_z0_o      <= '0;
      tag_x0        <= '0;
      for (int i = 0; i < g_LATENCY; i++) tag_pipe[i] <= '0;
      inflight      <= '0;
      rsp_valid_o   <= '0;
      rsp_x_o       <= '0;
      rsp_y_o       <= '0;
      rsp_z_o       <= '0;
    end else begin
      if (grant) begin
        cor_x0_o <= win_x;
        cor_y0_o <= win_y;
        cor_z0_o <= win_z;
        tag_x0   <= '{valid: 1'b1, idx: c_IDX_W'(win_idx)};
        rr_ptr   <= (win_idx == c_IW'(g_NUM_REQ - 1)) ? '0 : win_idx + c_IW'(1);
      end else begin
        cor_x0_o <= '0;
        cor_y0_o <= '0;
        cor_z0_o <= '0;
        tag_x0   <= '0;
      end

      tag_pipe[0] <= tag_x0;
      for (int i = 1; i < g_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];

      if (pend_load) pend_idx <= win_idx;
      if (mode_load) begin
        cor_mode_o    <= pend_mode;
        cor_submode_o <= pend_sub;
      end

      case ({grant, retire})
        2'b10:   inflight <= inflight + c_CW'(1);
        2'b01:   inflight <= inflight - c_CW'(1);
        default: inflight <= inflight;
      endcase

      rsp_valid_o <= ret_onehot;
      if (retire) begin
        rsp_x_o <= cor_xn_i;
        rsp_y_o <= cor_yn_i;
        rsp_z_o <= cor_zn_i;
      end
    end
  end

endmodule

// File: tb/tb_gc_cordic_arbiter.sv
// tb/tb_gc_cordic_arbiter.sv - randomized and directed bench against a queue-based reference model
module tb_gc_cordic_arbiter;

  localparam int N = 4;
  localparam int W = 16;
  localparam int L = 17;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid, req_ready, req_mode, rsp_valid;
  logic [2*N-1:0] req_sub;
  logic [W*N-1:0] req_x, req_y, req_z;
  logic [W-1:0]   rsp_x, rsp_y, rsp_z;
  logic [W-1:0]   cor_x0, cor_y0, cor_z0, cor_xn, cor_yn, cor_zn;
  logic           cor_mode, busy;
  logic [1:0]     cor_sub;

  always #5 clk = ~clk;

  gc_cordic_arbiter #(.g_NUM_REQ(N), .g_N(W), .g_LATENCY(L)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_mode_i(req_mode), .req_submode_i(req_sub),
    .req_x_i(req_x), .req_y_i(req_y), .req_z_i(req_z),
    .rsp_valid_o(rsp_valid), .rsp_x_o(rsp_x), .rsp_y_o(rsp_y), .rsp_z_o(rsp_z),
    .cor_mode_o(cor_mode), .cor_submode_o(cor_sub),
    .cor_x0_o(cor_x0), .cor_y0_o(cor_y0), .cor_z0_o(cor_z0),
    .cor_xn_i(cor_xn), .cor_yn_i(cor_yn), .cor_zn_i(cor_zn),
    .busy_o(busy)
  );

  // Requester drive state
  logic       r_v [N];
  logic       r_m [N];
  logic [1:0] r_s [N];
  logic [W-1:0] r_x [N], r_y [N], r_z [N];

  always_comb begin
    req_valid = '0; req_mode = '0; req_sub = '0; req_x = '0; req_y = '0; req_z = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = r_v[i];
      req_mode[i]         = r_m[i];
      req_sub[2*i +: 2]   = r_s[i];
      req_x[i*W +: W]     = r_x[i];
      req_y[i*W +: W]     = r_y[i];
      req_z[i*W +: W]     = r_z[i];
    end
  end

  // Stand-in CORDIC: fixed delay plus a mode-dependent marking of the result.
  function automatic logic [W-1:0] f_x(input logic [W-1:0] x, input logic m, input logic [1:0] s);
    return x + (m ? 16'd1 : 16'd7) + {13'd0, s, 1'b0};
  endfunction
  function automatic logic [W-1:0] f_y(input logic [W-1:0] y);
    return y ^ 16'h00ff;
  endfunction
  function automatic logic [W-1:0] f_z(input logic [W-1:0] z);
    return z - 16'd5;
  endfunction

  logic [W-1:0] dx [L], dy [L], dz [L];
  always @(posedge clk) begin
    dx[0] <= cor_x0; dy[0] <= cor_y0; dz[0] <= cor_z0;
    for (int k = 1; k < L; k++) begin
      dx[k] <= dx[k-1]; dy[k] <= dy[k-1]; dz[k] <= dz[k-1];
    end
  end
  assign cor_xn = f_x(dx[L-1], cor_mode, cor_sub);
  assign cor_yn = f_y(dy[L-1]);
  assign cor_zn = f_z(dz[L-1]);

  // Reference model
  typedef struct {
    int           due;
    int           idx;
    logic [W-1:0] x, y, z;
  } op_t;

  op_t          oq [$];
  int           edges, m_ptr, m_pend, m_gnt;
  bit           m_drain;
  logic         m_mode;
  logic [1:0]   m_sub;
  logic [W-1:0] m_x0, m_y0, m_z0, m_rx, m_ry, m_rz;
  logic [N-1:0] m_rv;
  int           n_checks = 0;
  int           n_pass   = 0;
  int           refill   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    oq.delete();
    edges = 0; m_ptr = 0; m_pend = 0; m_gnt = -1; m_drain = 0;
    m_mode = 1'b1; m_sub = 2'b00;
    m_x0 = '0; m_y0 = '0; m_z0 = '0; m_rx = '0; m_ry = '0; m_rz = '0; m_rv = '0;
  endtask

  task automatic eval_and_check();
    int           w, j, infl;
    logic [N-1:0] exp_ready;
    bit           gnt, drain_nxt;
    op_t          o;
    w = -1;
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (w < 0 && r_v[j]) w = j;
    end
    exp_ready = '0; gnt = 0; drain_nxt = m_drain; m_gnt = -1; infl = oq.size();
    if (!m_drain && w >= 0) begin
      if (r_m[w] == m_mode && r_s[w] == m_sub) begin
        gnt = 1; exp_ready[w] = 1'b1;
      end else begin
        m_pend = w; drain_nxt = 1;
      end
    end

    chk("ready", req_ready, exp_ready);
    chk("busy", busy, (infl > 0 || m_drain));
    chk("cor_xyz0", {cor_x0, cor_y0, cor_z0}, {m_x0, m_y0, m_z0});
    chk("cor_mode", {cor_mode, cor_sub}, {m_mode, m_sub});
    chk("rsp_valid", rsp_valid, m_rv);
    chk("rsp_xyz", {rsp_x, rsp_y, rsp_z}, {m_rx, m_ry, m_rz});

    edges++;
    m_rv = '0;
    if (oq.size() > 0 && oq[0].due == edges) begin
      o = oq.pop_front();
      m_rv[o.idx] = 1'b1;
      m_rx = o.x; m_ry = o.y; m_rz = o.z;
    end
    if (m_drain) begin
      if (!r_v[m_pend]) drain_nxt = 0;
      else if (infl == 0) begin
        m_mode = r_m[m_pend]; m_sub = r_s[m_pend]; drain_nxt = 0;
      end
    end
    if (gnt) begin
      oq.push_back('{due: edges + L + 1, idx: w,
                     x: f_x(r_x[w], m_mode, m_sub), y: f_y(r_y[w]), z: f_z(r_z[w])});
      m_x0 = r_x[w]; m_y0 = r_y[w]; m_z0 = r_z[w];
      m_ptr = (w + 1) % N;
      m_gnt = w;
    end else begin
      m_x0 = '0; m_y0 = '0; m_z0 = '0;
    end
    m_drain = drain_nxt;
  endtask

  task automatic set_req(input int i, input logic v, input logic m, input logic [1:0] s,
                         input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
    r_v[i] = v; r_m[i] = m; r_s[i] = s; r_x[i] = x; r_y[i] = y; r_z[i] = z;
  endtask

  task automatic rand_op(input int i, input bit any_mode);
    logic [1:0] s;
    logic       m;
    s = 2'($urandom_range(0, 2));
    if (s == 2'd2) s = 2'd3;
    m = ($urandom_range(0, 9) < 8);
    if (!any_mode) begin m = m_mode; s = m_sub; end
    set_req(i, 1'b1, m, s, 16'($urandom), 16'($urandom), 16'($urandom));
  endtask

  task automatic drive_update();
    if (m_gnt >= 0) begin
      if (refill == 0) r_v[m_gnt] = 1'b0;
      else if (refill == 1) rand_op(m_gnt, 1'b0);
      else if ($urandom_range(0, 1) == 0) rand_op(m_gnt, 1'b1);
      else r_v[m_gnt] = 1'b0;
    end
    if (refill == 2) begin
      for (int i = 0; i < N; i++) begin
        if (i != m_gnt) begin
          if (!r_v[i] && $urandom_range(0, 3) == 0) rand_op(i, 1'b1);
          else if (r_v[i] && $urandom_range(0, 19) == 0) r_v[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    eval_and_check();
    @(posedge clk);
    #1;
    drive_update();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, req_ready, '0);
    chk({tag, "_rsp_valid"}, rsp_valid, '0);
    chk({tag, "_rsp_xyz"}, {rsp_x, rsp_y, rsp_z}, '0);
    chk({tag, "_cor_xyz0"}, {cor_x0, cor_y0, cor_z0}, '0);
    chk({tag, "_cor_mode"}, {cor_mode, cor_sub}, 3'b100);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int         a, b, c, issued;
    logic       saved_mode;
    logic [1:0] saved_sub;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b1, 2'b00, '0, '0, '0);
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    model_reset();

    // Single rotate/circular request on requester 0
    set_req(0, 1'b1, 1'b1, 2'b00, 16'd10000, 16'd0, 16'd0);
    repeat (22) step();

    // Vector/circular on requester 2 forces a drain and mode switch
    set_req(2, 1'b1, 1'b0, 2'b00, 16'd10000, 16'd10000, 16'd0);
    repeat (24) step();

    // All requesters continuously valid in rotate/circular
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, 2'b00, 16'(1000 * i + 7), 16'(i), 16'(3 * i));
    refill = 1;
    repeat (20) step();
    refill = 0;
    repeat (24) step();

    // Rotate on 0 and vector on 1 at once
    set_req(0, 1'b1, 1'b1, 2'b00, 16'h1234, 16'h0042, 16'h0100);
    set_req(1, 1'b1, 1'b0, 2'b00, 16'h2222, 16'h3333, 16'h4444);
    repeat (45) step();

    // Mismatching winner withdraws while draining
    a = m_ptr;
    set_req(a, 1'b1, m_mode, m_sub, 16'h0abc, 16'h0def, 16'h0123);
    step();
    saved_mode = m_mode;
    saved_sub  = m_sub;
    b = m_ptr;
    c = (b + 1) % N;
    set_req(b, 1'b1, ~m_mode, m_sub, 16'h5555, 16'h6666, 16'h7777);
    set_req(c, 1'b1, m_mode, m_sub, 16'h1111, 16'h2222, 16'h3333);
    repeat (4) step();
    r_v[b] = 1'b0;
    repeat (3) step();
    chk("drop_keeps_mode", {cor_mode, cor_sub}, {saved_mode, saved_sub});
    repeat (22) step();

    // Randomized traffic with mixed modes
    for (int i = 0; i < N; i++) rand_op(i, 1'b1);
    refill = 2;
    repeat (300) step();
    refill = 0;
    for (int i = 0; i < N; i++) r_v[i] = 1'b0;
    repeat (60) step();

    // Reset with operations in flight
    for (int i = 0; i < N; i++) rand_op(i, 1'b0);
    refill = 1;
    issued = 0;
    for (int t = 0; t < 20 && issued < 5; t++) begin
      step();
      if (m_gnt >= 0) issued++;
    end
    chk("issued_before_reset", issued, 5);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    refill = 0;
    for (int i = 0; i < N; i++) r_v[i] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    repeat (40) step();
    chk("post_reset_mode", {cor_mode, cor_sub}, 3'b100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
